arcade_rotary: RTL and testbench
================================

Name: arcade_rotary

Overview:
- Multi-player emulation of the arcade 8-way (or N-way) rotary joystick switch.
- Drives a one-hot position code per player from digital rotate-left/right buttons (relative mode) or from a target angle derived from an analog stick (absolute mode).
- In absolute mode it walks one position per tick, so games that reject out-of-order rotary codes see only legal sequences.
- Sits in the core top level between the input mapping and the game core; the top level inverts the outputs for active-low game inputs.

Parameters:
- NUM_PLAYERS, 2, number of independent rotary channels.
- POSITIONS, 8, number of detent positions and one-hot output width per player; power of two, 4..16.
- DIV_WIDTH, 23, normal-speed tick divider width; tick period is 2^DIV_WIDTH clocks.
- FAST_DIV_WIDTH, 22, fast-speed tick divider width; must be less than DIV_WIDTH.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- speed_fast  in  1  0 selects the DIV_WIDTH tick period, 1 selects the FAST_DIV_WIDTH tick period
- absolute_mode  in  1  1 enables target-following whenever that player's target_valid is high
- rotary_disable  in  1  1 forces all outputs to all-ones (bootleg sets that have no rotary hardware)
- rot_l  in  NUM_PLAYERS  per-player rotate-left request, active-high
- rot_r  in  NUM_PLAYERS  per-player rotate-right request, active-high
- target_valid  in  NUM_PLAYERS  per-player flag: analog stick outside deadzone
- target_pos  in  NUM_PLAYERS*$clog2(POSITIONS)  per-player target position index; player p occupies slice p
- rotary_out  out  NUM_PLAYERS*POSITIONS  per-player one-hot position, active-high; player p occupies slice p
- step  out  NUM_PLAYERS  one-cycle pulse in the cycle a player's position changes

Behaviour:
- Shared free-running divider div[DIV_WIDTH-1:0] increments every clk_sys cycle and wraps naturally.
- tick is high when the active low bits of div are all zero: div[FAST_DIV_WIDTH-1:0] when speed_fast=1, otherwise the whole div.
- speed_fast is sampled every cycle. There is no resynchronisation of the divider on a speed change.
- Each player holds a binary index pos. rotary_out slice = 1 << pos.
- Reset clears div and all pos to 0, so each rotary_out slice = 0...01. step = 0.
  - The first tick occurs in the first cycle with reset low, because div = 0 in that cycle.
- On a tick, relative mode applies when absolute_mode=0 or target_valid[p]=0:
  - rot_l[p]: pos <= pos+1 mod POSITIONS. For POSITIONS=8 this moves 0x80 -> 0x01.
  - else rot_r[p]: pos <= pos-1 mod POSITIONS. For POSITIONS=8 this moves 0x01 -> 0x80.
  - rot_l and rot_r together: left wins.
- On a tick, absolute mode applies when absolute_mode=1 and target_valid[p]=1:
  - rot_l and rot_r are ignored.
  - d = (target_pos - pos) mod POSITIONS.
  - d=0: hold.
  - 0<d<POSITIONS/2: step +1.
  - d>POSITIONS/2: step -1.
  - d=POSITIONS/2: tie, step +1.
  - Exactly one step per tick, with wrap.
- step[p] is registered. It is high in the cycle after a tick that changed pos[p], aligned with the new rotary_out.
- rotary_disable=1:
  - rotary_out = all ones and step = 0, combinationally.
  - pos is held at 0 and inputs are ignored.
  - Deasserting rotary_disable resumes from pos 0.
- Reset mid-walk: pos returns to 0 immediately. Target-following restarts from 0 on the next tick.
- Holding a target across many ticks converges in at most POSITIONS/2 ticks, then holds with no step pulses.
- Between ticks, rotary_out is stable. No glitches: outputs come directly from the pos register decode.

Decomposition:
- Package arcade_rotary_pkg:
  - function pos_w(POSITIONS) returning $clog2.
  - function onehot_dec.
  - typedef step_dir_t {HOLD, INC, DEC}.
- Sub-module arcade_rotary_channel: one player's pos register, direction decision (relative/absolute arbitration, shortest-path with tie-to-INC), step pulse.
  - Instantiated NUM_PLAYERS times by a generate loop.
  - The divider, tick and disable mux stay in arcade_rotary.

Test Plan:
- Bench parameters for all scenarios: DIV_WIDTH=4, FAST_DIV_WIDTH=2.
1. Reset released, nothing pressed -> rotary_out = 16'h0101 (both players), step=0 for 64 cycles.
2. P1 rot_l held, speed_fast=0 -> P1 out 01,02,04,...,80,01 changing every 16 cycles, with step[0] pulsing; P2 stays 01. Then speed_fast=1 -> changes every 4 cycles.
3. P1 rot_l and rot_r held together -> same sequence as rot_l only. Then rot_r only from 0x01 -> 0x80, 0x40.
4. absolute_mode=1, P1 target_valid=1, target_pos=6, pos=0 -> steps 0x01 -> 0x80 -> 0x40, then holds with no further step. Then target_pos=2 from pos 6 (tie d=4) -> 0x80, 0x01, 0x02, 0x04.
5. absolute_mode=1, target_valid=0, rot_l held -> relative stepping applies. Then target_valid=1 with rot_r held -> rot_r ignored and pos follows the target.
6. rotary_disable=1 mid-walk -> out=16'hFFFF and step=0. Release -> 16'h0101. reset asserted during the absolute walk -> 16'h0101 next cycle.

Source files
------------

// File: rtl/arcade_rotary_pkg.sv
// Shared types and helpers for the rotary joystick emulation.
// Position indices are binary; outputs are decoded one-hot per player.
package arcade_rotary_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } step_dir_t;

    localparam int MAX_POSITIONS = 16;

    function automatic int pos_w(input int positions);
        return $clog2(positions);
    endfunction

    // Returns bit bit_idx of the one-hot decode of idx.
    function automatic logic onehot_dec(input logic [3:0] idx, input int bit_idx);
        return (int'(idx) == bit_idx);
    endfunction

endpackage

// File: rtl/arcade_rotary_channel.sv
// One player's rotary position: relative/absolute arbitration,
// shortest-path walk toward a target, and the registered step pulse.
module arcade_rotary_channel
    import arcade_rotary_pkg::*;
#(
    parameter int POSITIONS = 8,
    parameter int PW        = pos_w(POSITIONS)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          tick,
    input  logic          hold_zero,
    input  logic          absolute_mode,
    input  logic          target_valid,
    input  logic          rot_l,
    input  logic          rot_r,
    input  logic [PW-1:0] target_pos,
    output logic [PW-1:0] pos,
    output logic          step
);

    localparam logic [PW-1:0] HALF = PW'(POSITIONS / 2);
    localparam logic [PW-1:0] ONE  = PW'(1);

    step_dir_t     dir;
    logic [PW-1:0] diff;

    // diff wraps modulo POSITIONS; an exact half-turn resolves toward INC.
    always_comb begin
        diff = target_pos - pos;
        dir  = HOLD;
        if (absolute_mode && target_valid) begin
            if (diff == '0) begin
                dir = HOLD;
            end else if (diff <= HALF) begin
                dir = INC;
            end else begin
                dir = DEC;
            end
        end else if (rot_l) begin
            dir = INC;
        end else if (rot_r) begin
            dir = DEC;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || hold_zero) begin
            pos  <= '0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (tick) begin
                case (dir)
                    INC:     pos <= pos + ONE;
                    DEC:     pos <= pos - ONE;
                    default: pos <= pos;
                endcase
                step <= (dir != HOLD);
            end
        end
    end

endmodule

// File: rtl/arcade_rotary.sv
// Multi-player rotary joystick emulation: shared tick divider, per-player
// channels, one-hot decode and the bootleg-board disable override.
module arcade_rotary
    import arcade_rotary_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int POSITIONS      = 8,
    parameter int DIV_WIDTH      = 23,
    parameter int FAST_DIV_WIDTH = 22
) (
    input  logic                                 clk_sys,
    input  logic                                 reset,
    input  logic                                 speed_fast,
    input  logic                                 absolute_mode,
    input  logic                                 rotary_disable,
    input  logic [NUM_PLAYERS-1:0]               rot_l,
    input  logic [NUM_PLAYERS-1:0]               rot_r,
    input  logic [NUM_PLAYERS-1:0]               target_valid,
    input  logic [NUM_PLAYERS*pos_w(POSITIONS)-1:0] target_pos,
    output logic [NUM_PLAYERS*POSITIONS-1:0]     rotary_out,
    output logic [NUM_PLAYERS-1:0]               step
);

    localparam int PW = pos_w(POSITIONS);

    logic [DIV_WIDTH-1:0]   div;
    logic                   tick;
    logic [NUM_PLAYERS-1:0] step_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= div + DIV_WIDTH'(1);
        end
    end

    // Speed changes take effect immediately; the divider is never realigned.
    always_comb begin
        if (speed_fast) begin
            tick = (div[FAST_DIV_WIDTH-1:0] == '0);
        end else begin
            tick = (div == '0);
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [PW-1:0]        pos_p;
        logic [POSITIONS-1:0] dec;

        arcade_rotary_channel #(
            .POSITIONS (POSITIONS),
            .PW        (PW)
        ) u_channel (
            .clk_sys       (clk_sys),
            .reset         (reset),
            .tick          (tick),
            .hold_zero     (rotary_disable),
            .absolute_mode (absolute_mode),
            .target_valid  (target_valid[p]),
            .rot_l         (rot_l[p]),
            .rot_r         (rot_r[p]),
            .target_pos    (target_pos[p*PW +: PW]),
            .pos           (pos_p),
            .step          (step_q[p])
        );

        for (genvar b = 0; b < POSITIONS; b++) begin : g_bit
            assign dec[b] = onehot_dec(4'(pos_p), b);
        end

        assign rotary_out[p*POSITIONS +: POSITIONS] = rotary_disable ? '1 : dec;
    end

    assign step = rotary_disable ? '0 : step_q;

endmodule

// File: tb/tb_arcade_rotary.sv
// Directed self-checking bench for arcade_rotary with a 16-clock slow tick
// and a 4-clock fast tick; outputs are sampled on the falling edge.
module tb_arcade_rotary;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        speed_fast = 1'b0;
    logic        absolute_mode = 1'b0;
    logic        rotary_disable = 1'b0;
    logic [1:0]  rot_l = 2'b00;
    logic [1:0]  rot_r = 2'b00;
    logic [1:0]  target_valid = 2'b00;
    logic [5:0]  target_pos = 6'd0;
    logic [15:0] rotary_out;
    logic [1:0]  step;

    int checks = 0;
    int failures = 0;

    arcade_rotary #(
        .NUM_PLAYERS    (2),
        .POSITIONS      (8),
        .DIV_WIDTH      (4),
        .FAST_DIV_WIDTH (2)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .speed_fast     (speed_fast),
        .absolute_mode  (absolute_mode),
        .rotary_disable (rotary_disable),
        .rot_l          (rot_l),
        .rot_r          (rot_r),
        .target_valid   (target_valid),
        .target_pos     (target_pos),
        .rotary_out     (rotary_out),
        .step           (step)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Enter reset with every input cleared; tests then set inputs and release.
    task automatic hold_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        speed_fast = 1'b0;
        absolute_mode = 1'b0;
        rotary_disable = 1'b0;
        rot_l = 2'b00;
        rot_r = 2'b00;
        target_valid = 2'b00;
        target_pos = 6'd0;
        cycles(2);
    endtask

    // Released on a falling edge, so the next rising edge is the first tick.
    task automatic release_reset();
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if (rotary_out !== 16'h0101) begin
            failures++;
            $display("[TB] FAIL reset_out: got %h expected %h", rotary_out, 16'h0101);
        end
        checks++;
        if (step !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_step: got %b expected %b", step, 2'b00);
        end
        release_reset();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (rotary_out !== 16'h0101 || step !== 2'b00) begin
                failures++;
                $display("[TB] FAIL idle cyc=%0d: got out=%h step=%b expected out=0101 step=00",
                         i, rotary_out, step);
            end
            cycles(1);
        end
    endtask

    task automatic test_rot_left();
        logic [7:0] seq [0:8];
        logic [7:0] fseq [0:3];
        seq  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        fseq = '{8'h02, 8'h04, 8'h08, 8'h10};
        hold_reset();
        rot_l = 2'b01;
        release_reset();
        checks++;
        if (rotary_out !== {8'h01, seq[0]} || step !== 2'b01) begin
            failures++;
            $display("[TB] FAIL left_first: got out=%h step=%b expected out=%h step=01",
                     rotary_out, step, {8'h01, seq[0]});
        end
        for (int k = 1; k <= 8; k++) begin
            cycles(15);
            checks++;
            if (rotary_out !== {8'h01, seq[k-1]} || step !== 2'b00) begin
                failures++;
                $display("[TB] FAIL left_stable k=%0d: got out=%h step=%b expected out=%h step=00",
                         k, rotary_out, step, {8'h01, seq[k-1]});
            end
            cycles(1);
            checks++;
            if (rotary_out !== {8'h01, seq[k]} || step !== 2'b01) begin
                failures++;
                $display("[TB] FAIL left_step k=%0d: got out=%h step=%b expected out=%h step=01",
                         k, rotary_out, step, {8'h01, seq[k]});
            end
        end
        speed_fast = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycles(3);
            checks++;
            if (rotary_out !== {8'h01, fseq[k-1]} || step !== 2'b00) begin
                failures++;
                $display("[TB] FAIL fast_stable k=%0d: got out=%h step=%b expected out=%h step=00",
                         k, rotary_out, step, {8'h01, fseq[k-1]});
            end
            cycles(1);
            checks++;
            if (rotary_out !== {8'h01, fseq[k]} || step !== 2'b01) begin
                failures++;
                $display("[TB] FAIL fast_step k=%0d: got out=%h step=%b expected out=%h step=01",
                         k, rotary_out, step, {8'h01, fseq[k]});
            end
        end
    endtask

    task automatic test_both_and_right();
        hold_reset();
        rot_l = 2'b01;
        rot_r = 2'b01;
        release_reset();
        checks++;
        if (rotary_out !== 16'h0102 || step !== 2'b01) begin
            failures++;
            $display("[TB] FAIL both_t0: got out=%h step=%b expected out=0102 step=01", rotary_out, step);
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0104) begin
            failures++;
            $display("[TB] FAIL both_t1: got %h expected 0104", rotary_out);
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0108) begin
            failures++;
            $display("[TB] FAIL both_t2: got %h expected 0108", rotary_out);
        end
        // P1 turns right from 0x01 while P2 turns left.
        hold_reset();
        rot_r = 2'b01;
        rot_l = 2'b10;
        release_reset();
        checks++;
        if (rotary_out !== 16'h0280 || step !== 2'b11) begin
            failures++;
            $display("[TB] FAIL right_t0: got out=%h step=%b expected out=0280 step=11", rotary_out, step);
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0440 || step !== 2'b11) begin
            failures++;
            $display("[TB] FAIL right_t1: got out=%h step=%b expected out=0440 step=11", rotary_out, step);
        end
    endtask

    task automatic test_absolute();
        logic [7:0] aseq [0:3];
        aseq = '{8'h80, 8'h01, 8'h02, 8'h04};
        hold_reset();
        absolute_mode = 1'b1;
        target_valid = 2'b01;
        target_pos = {3'd0, 3'd6};
        release_reset();
        checks++;
        if (rotary_out !== 16'h0180 || step !== 2'b01) begin
            failures++;
            $display("[TB] FAIL abs_t0: got out=%h step=%b expected out=0180 step=01", rotary_out, step);
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0140 || step !== 2'b01) begin
            failures++;
            $display("[TB] FAIL abs_t1: got out=%h step=%b expected out=0140 step=01", rotary_out, step);
        end
        for (int k = 0; k < 2; k++) begin
            cycles(16);
            checks++;
            if (rotary_out !== 16'h0140 || step !== 2'b00) begin
                failures++;
                $display("[TB] FAIL abs_hold k=%0d: got out=%h step=%b expected out=0140 step=00",
                         k, rotary_out, step);
            end
        end
        // Target 2 from 6 is exactly half a turn away, so it goes up.
        target_pos = {3'd0, 3'd2};
        for (int k = 0; k < 4; k++) begin
            cycles(16);
            checks++;
            if (rotary_out !== {8'h01, aseq[k]} || step !== 2'b01) begin
                failures++;
                $display("[TB] FAIL abs_tie k=%0d: got out=%h step=%b expected out=%h step=01",
                         k, rotary_out, step, {8'h01, aseq[k]});
            end
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0104 || step !== 2'b00) begin
            failures++;
            $display("[TB] FAIL abs_settle: got out=%h step=%b expected out=0104 step=00", rotary_out, step);
        end
    endtask

    task automatic test_mode_arbitration();
        logic [15:0] exp_out [0:3];
        logic [1:0]  exp_step [0:3];
        exp_out  = '{16'h0208, 16'h0410, 16'h0820, 16'h1020};
        exp_step = '{2'b11, 2'b11, 2'b11, 2'b10};
        hold_reset();
        absolute_mode = 1'b1;
        target_pos = {3'd0, 3'd5};
        rot_l = 2'b01;
        release_reset();
        checks++;
        if (rotary_out !== 16'h0102 || step !== 2'b01) begin
            failures++;
            $display("[TB] FAIL arb_rel_t0: got out=%h step=%b expected out=0102 step=01", rotary_out, step);
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0104) begin
            failures++;
            $display("[TB] FAIL arb_rel_t1: got %h expected 0104", rotary_out);
        end
        // P1 now follows target 5 and ignores rot_r; P2 has no target and turns left.
        target_valid = 2'b01;
        rot_r = 2'b01;
        rot_l = 2'b10;
        for (int k = 0; k < 4; k++) begin
            cycles(16);
            checks++;
            if (rotary_out !== exp_out[k] || step !== exp_step[k]) begin
                failures++;
                $display("[TB] FAIL arb_abs k=%0d: got out=%h step=%b expected out=%h step=%b",
                         k, rotary_out, step, exp_out[k], exp_step[k]);
            end
        end
    endtask

    task automatic test_disable_and_reset();
        hold_reset();
        rot_l = 2'b01;
        release_reset();
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0104) begin
            failures++;
            $display("[TB] FAIL dis_pre: got %h expected 0104", rotary_out);
        end
        cycles(4);
        rotary_disable = 1'b1;
        #1;
        checks++;
        if (rotary_out !== 16'hFFFF || step !== 2'b00) begin
            failures++;
            $display("[TB] FAIL dis_on: got out=%h step=%b expected out=ffff step=00", rotary_out, step);
        end
        cycles(12);
        checks++;
        if (rotary_out !== 16'hFFFF || step !== 2'b00) begin
            failures++;
            $display("[TB] FAIL dis_tick: got out=%h step=%b expected out=ffff step=00", rotary_out, step);
        end
        cycles(1);
        rotary_disable = 1'b0;
        #1;
        checks++;
        if (rotary_out !== 16'h0101 || step !== 2'b00) begin
            failures++;
            $display("[TB] FAIL dis_off: got out=%h step=%b expected out=0101 step=00", rotary_out, step);
        end
        cycles(15);
        checks++;
        if (rotary_out !== 16'h0102 || step !== 2'b01) begin
            failures++;
            $display("[TB] FAIL dis_resume: got out=%h step=%b expected out=0102 step=01", rotary_out, step);
        end
        // Reset in the middle of an absolute walk on both players.
        hold_reset();
        absolute_mode = 1'b1;
        target_valid = 2'b11;
        target_pos = {3'd3, 3'd6};
        release_reset();
        checks++;
        if (rotary_out !== 16'h0280 || step !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rst_walk_t0: got out=%h step=%b expected out=0280 step=11", rotary_out, step);
        end
        cycles(8);
        reset = 1'b1;
        cycles(1);
        checks++;
        if (rotary_out !== 16'h0101 || step !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rst_walk_mid: got out=%h step=%b expected out=0101 step=00", rotary_out, step);
        end
        reset = 1'b0;
        cycles(1);
        checks++;
        if (rotary_out !== 16'h0280 || step !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rst_walk_restart: got out=%h step=%b expected out=0280 step=11", rotary_out, step);
        end
        cycles(16);
        checks++;
        if (rotary_out !== 16'h0440 || step !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rst_walk_t1: got out=%h step=%b expected out=0440 step=11", rotary_out, step);
        end
    endtask

    initial begin
        test_reset();
        test_rot_left();
        test_both_and_right();
        test_absolute();
        test_mode_arbitration();
        test_disable_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
